// File: rtl/iob_iob2axil.sv
// IOb subordinate to AXI-Lite manager bridge, one outstanding transaction.
// Optional sticky response-error flag: define IOB_IOB2AXIL_ERR_EN to add err_o/err_clr_i.
module iob_iob2axil #(
  parameter int AXIL_ADDR_W = 21,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_i,
`ifdef IOB_IOB2AXIL_ERR_EN
  input  logic                     err_clr_i,
  output logic                     err_o,
`endif
  input  logic                     iob_valid_i,
  input  logic [ADDR_W-1:0]        iob_addr_i,
  input  logic [DATA_W-1:0]        iob_wdata_i,
  input  logic [DATA_W/8-1:0]      iob_wstrb_i,
  output logic                     iob_ready_o,
  output logic                     iob_rvalid_o,
  output logic [DATA_W-1:0]        iob_rdata_o,
  input  logic                     iob_rready_i,
  output logic                     axil_awvalid_o,
  input  logic                     axil_awready_i,
  output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
  output logic                     axil_wvalid_o,
  input  logic                     axil_wready_i,
  output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
  input  logic                     axil_bvalid_i,
  output logic                     axil_bready_o,
  input  logic [1:0]               axil_bresp_i,
  output logic                     axil_arvalid_o,
  input  logic                     axil_arready_i,
  output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
  input  logic                     axil_rvalid_i,
  output logic                     axil_rready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]               axil_rresp_i
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_B, RD_AR, RD_R, RD_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic [AXIL_ADDR_W-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_W-1:0]   wdata_q, wdata_d;
  logic [AXIL_DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, rvalid_q, rvalid_d;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state_q   <= IDLE;
        addr_q    <= '0;
        wdata_q   <= '0;
        wstrb_q   <= '0;
        rdata_q   <= '0;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        rvalid_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        wstrb_q   <= wstrb_d;
        rdata_q   <= rdata_d;
        awvalid_q <= awvalid_d;
        wvalid_q  <= wvalid_d;
        bready_q  <= bready_d;
        arvalid_q <= arvalid_d;
        rready_q  <= rready_d;
        rvalid_q  <= rvalid_d;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rvalid_d  = rvalid_q;
    unique case (state_q)
      IDLE: begin
        if (iob_valid_i) begin
          addr_d  = AXIL_ADDR_W'(iob_addr_i);
          wdata_d = iob_wdata_i;
          wstrb_d = iob_wstrb_i;
          if (|iob_wstrb_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        // AW and W retire independently; B opens once both valids have dropped
        if (axil_awready_i) awvalid_d = 1'b0;
        if (axil_wready_i)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (axil_bvalid_i) begin
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_AR: begin
        if (axil_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (axil_rvalid_i) begin
          rdata_d  = axil_rdata_i;
          rready_d = 1'b0;
          rvalid_d = 1'b1;
          state_d  = RD_RESP;
        end
      end
      RD_RESP: begin
        if (iob_rready_i) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign iob_ready_o    = (state_q == IDLE);
  assign iob_rvalid_o   = rvalid_q;
  assign iob_rdata_o    = rdata_q;
  assign axil_awvalid_o = awvalid_q;
  assign axil_awaddr_o  = addr_q;
  assign axil_wvalid_o  = wvalid_q;
  assign axil_wdata_o   = wdata_q;
  assign axil_wstrb_o   = wstrb_q;
  assign axil_bready_o  = bready_q;
  assign axil_arvalid_o = arvalid_q;
  assign axil_araddr_o  = addr_q;
  assign axil_rready_o  = rready_q;

`ifdef IOB_IOB2AXIL_ERR_EN
  logic err_q, err_d, err_set;

  assign err_set = (state_q == WR_B && axil_bvalid_i && axil_bresp_i != 2'b00) ||
                   (state_q == RD_R && axil_rvalid_i && axil_rresp_i != 2'b00);

  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{axil_bresp_i, axil_rresp_i};
`endif

endmodule

// File: tb/tb_iob_iob2axil.sv
// Self-checking bench for iob_iob2axil: directed cycle checks plus a payload scoreboard.
module tb_iob_iob2axil;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        rst = 1'b1;
  logic        iob_valid = 1'b0;
  logic [20:0] iob_addr = '0;
  logic [31:0] iob_wdata = '0;
  logic [3:0]  iob_wstrb = '0;
  logic        iob_ready, iob_rvalid;
  logic [31:0] iob_rdata;
  logic        iob_rready = 1'b1;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [20:0] awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [31:0] rdata = '0;
`ifdef IOB_IOB2AXIL_ERR_EN
  logic        err, err_clr = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // subordinate knobs
  int          aw_hold = 1;
  int          aw_cnt  = 0;
  logic        b_hold  = 1'b0;
  logic [1:0]  sub_bresp = 2'b00;
  logic [31:0] sub_rdata = '0;

  logic [20:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [20:0] exp_ar[$];
  logic [31:0] exp_r[$];

  iob_iob2axil #(.AXIL_ADDR_W(21), .AXIL_DATA_W(32)) dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst),
`ifdef IOB_IOB2AXIL_ERR_EN
    .err_clr_i(err_clr), .err_o(err),
`endif
    .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
    .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
    .iob_rdata_o(iob_rdata), .iob_rready_i(iob_rready),
    .axil_awvalid_o(awvalid), .axil_awready_i(awready), .axil_awaddr_o(awaddr),
    .axil_wvalid_o(wvalid), .axil_wready_i(wready), .axil_wdata_o(wdata),
    .axil_wstrb_o(wstrb), .axil_bvalid_i(bvalid), .axil_bready_o(bready),
    .axil_bresp_i(bresp), .axil_arvalid_o(arvalid), .axil_arready_i(arready),
    .axil_araddr_o(araddr), .axil_rvalid_i(rvalid), .axil_rready_o(rready),
    .axil_rdata_i(rdata), .axil_rresp_i(rresp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Subordinate responses for the coming rising edge, then scoreboard on the handshakes.
  always @(negedge clk) begin
    if (awvalid) begin
      awready = (aw_cnt == aw_hold - 1);
      aw_cnt++;
    end else begin
      awready = 1'b0;
      aw_cnt  = 0;
    end
    wready  = wvalid;
    arready = arvalid;
    bvalid  = bready && !b_hold;
    bresp   = sub_bresp;
    rvalid  = rready;
    rdata   = sub_rdata;
    rresp   = 2'b00;
    #1;
    if (awvalid && awready) begin
      if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else check("awaddr", awaddr, exp_aw.pop_front());
    end
    if (wvalid && wready) begin
      if (exp_w.size() == 0) check("w_unexpected", 1, 0);
      else check("wdata_wstrb", {wdata, wstrb}, exp_w.pop_front());
    end
    if (arvalid && arready) begin
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else check("araddr", araddr, exp_ar.pop_front());
    end
    if (iob_rvalid && iob_rready) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else check("iob_rdata", iob_rdata, exp_r.pop_front());
    end
  end

  // Present a request at a falling edge; returns at the falling edge of the cycle after acceptance.
  task automatic issue(input logic [20:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    iob_valid = 1'b1;
    iob_addr  = a;
    iob_wdata = d;
    iob_wstrb = s;
    n = 0;
    while (!iob_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n < 50, 1);
    if (s != 4'h0) begin
      exp_aw.push_back(a);
      exp_w.push_back({d, s});
    end else begin
      exp_ar.push_back(a);
      exp_r.push_back(sub_rdata);
    end
    @(negedge clk);
    iob_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", iob_ready, 1);
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready, iob_rvalid}, 0);
    check("rst_payload", {awaddr, wdata, wstrb, iob_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // zero-wait write
    issue(21'h10, 32'hDEADBEEF, 4'hF);
    check("w1_c1_valids", {awvalid, wvalid, bready, iob_ready}, 4'b1100);
    check("w1_c1_payload", {awaddr, wdata, wstrb}, {21'h10, 32'hDEADBEEF, 4'hF});
    @(negedge clk);
    check("w1_c2", {awvalid, wvalid, bready, iob_ready}, 4'b0010);
    @(negedge clk);
    check("w1_c3", {bready, iob_ready}, 2'b01);

    // zero-wait read
    sub_rdata = 32'h12345678;
    issue(21'h24, 32'h0, 4'h0);
    check("r1_c1", {arvalid, rready, araddr}, {2'b10, 21'h24});
    @(negedge clk);
    check("r1_c2", {arvalid, rready, iob_rvalid}, 3'b010);
    @(negedge clk);
    check("r1_c3", {iob_rvalid, rready, iob_rdata}, {2'b10, 32'h12345678});
    @(negedge clk);
    check("r1_c4", {iob_rvalid, iob_ready}, 2'b01);

    // awready delayed, wready immediate
    aw_hold = 3;
    issue(21'h40, 32'hA5A50F0F, 4'h3);
    check("w2_c1", {awvalid, wvalid, bready, wstrb}, {3'b110, 4'h3});
    @(negedge clk);
    check("w2_c2", {awvalid, wvalid, bready, wstrb}, {3'b100, 4'h3});
    @(negedge clk);
    check("w2_c3", {awvalid, wvalid, bready, awaddr}, {3'b100, 21'h40});
    @(negedge clk);
    check("w2_c4", {awvalid, wvalid, bready, iob_ready}, 4'b0010);
    @(negedge clk);
    check("w2_c5", iob_ready, 1);
    aw_hold = 1;

    // read with iob_rready held low
    iob_rready = 1'b0;
    sub_rdata  = 32'hCAFEF00D;
    issue(21'h1FFFFC, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("r2_hold", {iob_rvalid, iob_ready, iob_rdata}, {2'b10, 32'hCAFEF00D});
      if (i == 3) iob_rready = 1'b1;
      @(negedge clk);
    end
    check("r2_done", {iob_rvalid, iob_ready}, 2'b01);

    // reset while waiting for B
    b_hold = 1'b1;
    issue(21'h55, 32'h01020304, 4'h8);
    @(negedge clk);
    check("rst_wrb_pre", bready, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wrb", {iob_ready, awvalid, wvalid, bready, arvalid, rready, iob_rvalid}, 7'b1000000);
    rst = 1'b0;
    b_hold = 1'b0;
    @(negedge clk);

`ifdef IOB_IOB2AXIL_ERR_EN
    check("err_init", err, 0);
    sub_bresp = 2'b10;
    issue(21'h60, 32'h11111111, 4'h1);
    repeat (2) @(negedge clk);
    check("err_set_b", err, 1);
    sub_bresp = 2'b00;
    sub_rdata = 32'h0BADF00D;
    issue(21'h64, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("err_sticky", {err, iob_ready}, 2'b11);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", err, 0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drain", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_r.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
